// File: rtl/tmr_sram_scrub.sv
// Triple-redundant word memory with bitwise 2-of-3 voted reads and a background
// scrubber that rewrites the voted word wherever the three copies disagree.
module tmr_sram_scrub #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              err_single,
  output logic              err_multi,
  input  logic              scrub_en,
  output logic              scrub_pass,
  output logic [CNT_W-1:0]  corr_count
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, READ, CHECK, FIX} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] copy0 [DEPTH];
  logic [DATA_W-1:0] copy1 [DEPTH];
  logic [DATA_W-1:0] copy2 [DEPTH];
  logic [ADDR_W-1:0] scrub_ptr_reg;
  logic [DATA_W-1:0] smp0_reg, smp1_reg, smp2_reg;

  logic              user_rd, user_wr;
  logic [DATA_W-1:0] rd_word0, rd_word1, rd_word2, rd_vote;
  logic [1:0]        rd_miss;
  logic [DATA_W-1:0] scrub_vote;
  logic              scrub_miss;
  logic              smp_load, scrub_wr, ptr_inc;

  assign user_rd = enable & ~we;
  assign user_wr = enable & we;

  always_comb begin
    rd_word0 = copy0[addr];
    rd_word1 = copy1[addr];
    rd_word2 = copy2[addr];
    rd_vote  = (rd_word0 & rd_word1) | (rd_word0 & rd_word2) | (rd_word1 & rd_word2);
    rd_miss  = {1'b0, rd_word0 != rd_vote} + {1'b0, rd_word1 != rd_vote}
             + {1'b0, rd_word2 != rd_vote};
  end

  assign scrub_vote = (smp0_reg & smp1_reg) | (smp0_reg & smp2_reg) | (smp1_reg & smp2_reg);
  assign scrub_miss = (smp0_reg != scrub_vote) | (smp1_reg != scrub_vote)
                    | (smp2_reg != scrub_vote);

  // Any user access or dropping scrub_en abandons the current scrub step.
  always_comb begin
    state_next = state_reg;
    smp_load   = 1'b0;
    scrub_wr   = 1'b0;
    ptr_inc    = 1'b0;
    if (!scrub_en || enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:  state_next = READ;
        READ: begin
          smp_load   = 1'b1;
          state_next = CHECK;
        end
        CHECK: begin
          if (scrub_miss) begin
            state_next = FIX;
          end else begin
            ptr_inc    = 1'b1;
            state_next = IDLE;
          end
        end
        FIX: begin
          scrub_wr   = 1'b1;
          ptr_inc    = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Memory contents survive reset; only writes are blocked while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (user_wr) begin
        copy0[addr] <= data_in;
        copy1[addr] <= data_in;
        copy2[addr] <= data_in;
      end else if (scrub_wr) begin
        copy0[scrub_ptr_reg] <= scrub_vote;
        copy1[scrub_ptr_reg] <= scrub_vote;
        copy2[scrub_ptr_reg] <= scrub_vote;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (smp_load) begin
      smp0_reg <= copy0[scrub_ptr_reg];
      smp1_reg <= copy1[scrub_ptr_reg];
      smp2_reg <= copy2[scrub_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      rd_valid   <= 1'b0;
      err_single <= 1'b0;
      err_multi  <= 1'b0;
    end else begin
      rd_valid   <= user_rd;
      err_single <= user_rd && (rd_miss == 2'd1);
      err_multi  <= user_rd && (rd_miss >= 2'd2);
      if (user_rd) begin
        data_out <= rd_vote;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      scrub_ptr_reg <= '0;
      scrub_pass    <= 1'b0;
      corr_count    <= '0;
    end else begin
      state_reg  <= state_next;
      scrub_pass <= ptr_inc && (&scrub_ptr_reg);
      if (ptr_inc) begin
        scrub_ptr_reg <= scrub_ptr_reg + 1'b1;
      end
      if (scrub_wr && (corr_count != '1)) begin
        corr_count <= corr_count + 1'b1;
      end
    end
  end
endmodule

// File: doc/tmr_sram_scrub.md
TMR_SRAM_SCRUB -- requirements
Module: tmr_sram_scrub

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width; depth = 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, word width.
REQ-003 SHALL have parameter CNT_W, default 16, correction counter width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  user access request, one access per cycle.
REQ-007 SHALL have port we  input  1  1 = write, 0 = read; qualified by enable.
REQ-008 SHALL have port addr  input  ADDR_W  user address.
REQ-009 SHALL have port data_in  input  DATA_W  user write data.
REQ-010 SHALL have port data_out  output  DATA_W  registered voted read data.
REQ-011 SHALL have port rd_valid  output  1  one-cycle pulse marking a valid data_out.
REQ-012 SHALL have port err_single  output  1  valid with rd_valid; exactly one copy mismatched.
REQ-013 SHALL have port err_multi  output  1  valid with rd_valid; two or more copies mismatched.
REQ-014 SHALL have port scrub_en  input  1  enables the background scrubber.
REQ-015 SHALL have port scrub_pass  output  1  one-cycle pulse when the scrub pointer wraps.
REQ-016 SHALL have port corr_count  output  CNT_W  number of scrubber corrections, saturating.

Function
REQ-017 SHALL hold three independent copies (copy0..copy2) of a 2^ADDR_W x DATA_W array.
REQ-018 User write (enable=1, we=1) SHALL write data_in to addr in all three copies at that clock edge.
REQ-019 User read (enable=1, we=0) SHALL present the bitwise 2-of-3 majority of the three copies on data_out one cycle later, with rd_valid=1 in that cycle.
REQ-020 Per-copy mismatch SHALL be defined as copy_i != voted word; err_single = exactly one mismatch; err_multi = two or three mismatches; both are 0 when rd_valid=0.
REQ-021 data_out SHALL hold its last value when rd_valid=0.
REQ-022 The scrubber FSM SHALL use states IDLE, READ, CHECK, FIX.
REQ-023 IDLE -> READ when scrub_en=1 and enable=0; READ samples the three copies at scrub_ptr.
REQ-024 READ -> CHECK next cycle; CHECK compares the copies and goes to FIX on any mismatch, otherwise to IDLE with scrub_ptr incremented.
REQ-025 FIX SHALL write the voted word to all three copies at scrub_ptr, increment corr_count, increment scrub_ptr and return to IDLE, in a cycle where enable=0.
REQ-026 User access SHALL always have priority; enable=1 in READ, CHECK or FIX SHALL abort the scrub step (no scrubber write, scrub_ptr unchanged, next state IDLE).
REQ-027 scrub_en=0 SHALL return the FSM to IDLE at the next edge without writing; scrub_ptr is retained.
REQ-028 scrub_ptr SHALL wrap from 2^ADDR_W-1 to 0 and pulse scrub_pass in the cycle after the wrap.
REQ-029 corr_count SHALL saturate at 2^CNT_W-1.
REQ-030 User reads SHALL NOT modify memory; correction is performed only by the scrubber.

Reset
REQ-031 While rst_n=0 at a clock edge: data_out=0, rd_valid=0, err_single=0, err_multi=0, scrub_pass=0, corr_count=0, scrub_ptr=0, FSM=IDLE.
REQ-032 Memory copies SHALL NOT be cleared by reset; any user or scrubber write in the reset cycle SHALL be suppressed.
REQ-033 Reset asserted during FIX SHALL suppress the write and SHALL leave corr_count=0.

Verification
REQ-034 Write 0x2C@10, 0x3C@20, 0xA5@30, then read 10/20/30 -> data_out 0x2C/0x3C/0xA5 one cycle after each read, rd_valid=1, no error flags.
REQ-035 Force copy1[10]=0x00, read 10 -> data_out=0x2C, err_single=1, err_multi=0; copy1[10] still 0x00 afterwards.
REQ-036 Set copy0[20]=0x11 and copy1[20]=0x22 (copy2=0x3C), read 20 -> data_out=0x30, err_multi=1, err_single=0.
REQ-037 Set copy2[30]=0x00, scrub_en=1, enable=0 for one full pass -> copy2[30]=0xA5, corr_count=1, scrub_pass pulses once.
REQ-038 Assert enable=1 in the CHECK cycle of a mismatching address -> no scrubber write, scrub_ptr unchanged, corr_count unchanged.
REQ-039 Drive rst_n=0 in the FIX cycle -> no write, all outputs at reset values, scrub_ptr=0 on the next cycle.
